rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_if.sv | 33 +++
 rtl/rom_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rom_loader_if.sv
// HPS download port and ROM write-side bus of the ROM loader.
interface rom_loader_if;
  localparam int unsigned AW = 27;
  localparam int unsigned IW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned SW = 4;

  logic          ioctl_download;
  logic [IW-1:0] ioctl_index;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_dout;
  logic          ioctl_wait;
  logic          rom_we;
  logic [SW-1:0] rom_sel;
  logic [OW-1:0] rom_addr;
  logic [BW-1:0] rom_data;
  logic [BW-1:0] dsw;
  logic [BW-1:0] title;
  logic          loaded;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, rom_we, rom_sel, rom_addr, rom_data, dsw, title, loaded
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, rom_we, rom_sel, rom_addr, rom_data, dsw, title, loaded
  );
endinterface

// File: rtl/rom_loader.sv
// Splits 16-bit HPS ROM download words into two region-decoded byte writes,
// with a one-entry skid buffer; also captures the title and DIP bytes.
module rom_loader #(
  parameter logic [26:0] R1_BASE     = 27'h08000,
  parameter logic [26:0] R2_BASE     = 27'h0E000,
  parameter logic [26:0] R3_BASE     = 27'h12000,
  parameter logic [26:0] ROM_END     = 27'h12400,
  parameter logic [7:0]  DSW_DEFAULT = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  rom_loader_if.slave bus
);
  localparam int unsigned AW = 27;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned SW = 4;

  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_TITLE = 8'd1;
  localparam logic [7:0] IDX_DIP   = 8'd254;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t        state_q, state_d;
  logic          skid_full_q, skid_full_d;
  logic [AW-1:0] skid_addr_q, skid_addr_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic [SW-1:0] cur_sel_q, cur_sel_d;
  logic [OW-1:0] cur_off_q, cur_off_d;
  logic [BW-1:0] cur_hi_q, cur_hi_d;
  logic          rom_we_q, rom_we_d;
  logic [SW-1:0] rom_sel_q, rom_sel_d;
  logic [OW-1:0] rom_addr_q, rom_addr_d;
  logic [BW-1:0] rom_data_q, rom_data_d;
  logic [BW-1:0] dsw_q, dsw_d;
  logic [BW-1:0] title_q, title_d;
  logic          loaded_q, loaded_d;
  logic          load_pend_q, load_pend_d;
  logic          dl_prev_q;

  logic          rom_wr_c;
  logic          launch_c;
  logic          fall_c;
  logic          idle_c;
  logic [AW-1:0] src_addr_c;
  logic [DW-1:0] src_data_c;
  logic [SW-1:0] src_sel_c;
  logic [OW-1:0] src_off_c;

  function automatic logic [SW-1:0] region_sel(input logic [AW-1:0] a);
    if (a < R1_BASE)      return 4'b0001;
    else if (a < R2_BASE) return 4'b0010;
    else if (a < R3_BASE) return 4'b0100;
    else if (a < ROM_END) return 4'b1000;
    else                  return 4'b0000;
  endfunction

  function automatic logic [OW-1:0] region_off(input logic [AW-1:0] a);
    logic [AW-1:0] base;
    if (a < R1_BASE)      base = '0;
    else if (a < R2_BASE) base = R1_BASE;
    else if (a < R3_BASE) base = R2_BASE;
    else                  base = R3_BASE;
    return OW'(a - base);
  endfunction

  assign rom_wr_c   = bus.ioctl_download && bus.ioctl_wr && (bus.ioctl_index == IDX_ROM);
  // A waiting skid entry always goes ahead of a live strobe.
  assign src_addr_c = skid_full_q ? skid_addr_q : bus.ioctl_addr;
  assign src_data_c = skid_full_q ? skid_data_q : bus.ioctl_dout;
  assign src_sel_c  = region_sel(src_addr_c);
  assign src_off_c  = region_off(src_addr_c);
  assign fall_c     = dl_prev_q && !bus.ioctl_download && (bus.ioctl_index == IDX_ROM);
  assign idle_c     = (state_q == IDLE) && !skid_full_q;

  // Byte-split FSM and skid buffer.
  always_comb begin
    state_d     = state_q;
    skid_full_d = skid_full_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    cur_sel_d   = cur_sel_q;
    cur_off_d   = cur_off_q;
    cur_hi_d    = cur_hi_q;
    rom_we_d    = 1'b0;
    rom_sel_d   = rom_sel_q;
    rom_addr_d  = rom_addr_q;
    rom_data_d  = rom_data_q;
    launch_c    = 1'b0;

    unique case (state_q)
      IDLE, HI: begin
        launch_c = skid_full_q || rom_wr_c;
        if (!launch_c) state_d = IDLE;
      end
      LO: begin
        state_d   = HI;
        rom_we_d  = |cur_sel_q;
        rom_sel_d = cur_sel_q;
        if (|cur_sel_q) begin
          rom_addr_d = cur_off_q + OW'(1);
          rom_data_d = cur_hi_q;
        end
        if (rom_wr_c && !skid_full_q) begin
          skid_full_d = 1'b1;
          skid_addr_d = bus.ioctl_addr;
          skid_data_d = bus.ioctl_dout;
        end
      end
      default: state_d = IDLE;
    endcase

    // Start a word: low byte now, high byte parked for the HI cycle.
    if (launch_c) begin
      state_d     = LO;
      skid_full_d = 1'b0;
      cur_sel_d   = src_sel_c;
      cur_off_d   = src_off_c;
      cur_hi_d    = src_data_c[DW-1:BW];
      rom_we_d    = |src_sel_c;
      rom_sel_d   = src_sel_c;
      if (|src_sel_c) begin
        rom_addr_d = src_off_c;
        rom_data_d = src_data_c[BW-1:0];
      end
    end
  end

  // Title/DIP capture and download-complete tracking.
  always_comb begin
    dsw_d   = dsw_q;
    title_d = title_q;
    if (bus.ioctl_wr && (bus.ioctl_index == IDX_TITLE)) title_d = bus.ioctl_dout[BW-1:0];
    if (bus.ioctl_wr && (bus.ioctl_index == IDX_DIP) && (bus.ioctl_addr[24:0] == 25'd0))
      dsw_d = bus.ioctl_dout[BW-1:0];
    loaded_d    = loaded_q || (idle_c && (fall_c || load_pend_q));
    load_pend_d = (load_pend_q || fall_c) && !loaded_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      skid_full_q <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      cur_sel_q   <= '0;
      cur_off_q   <= '0;
      cur_hi_q    <= '0;
      rom_we_q    <= 1'b0;
      rom_sel_q   <= '0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      dsw_q       <= DSW_DEFAULT;
      title_q     <= '0;
      loaded_q    <= 1'b0;
      load_pend_q <= 1'b0;
      dl_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      skid_full_q <= skid_full_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      cur_sel_q   <= cur_sel_d;
      cur_off_q   <= cur_off_d;
      cur_hi_q    <= cur_hi_d;
      rom_we_q    <= rom_we_d;
      rom_sel_q   <= rom_sel_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      dsw_q       <= dsw_d;
      title_q     <= title_d;
      loaded_q    <= loaded_d;
      load_pend_q <= load_pend_d;
      dl_prev_q   <= bus.ioctl_download;
    end
  end

  assign bus.ioctl_wait = skid_full_q;
  assign bus.rom_we     = rom_we_q;
  assign bus.rom_sel    = rom_sel_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_data   = rom_data_q;
  assign bus.dsw        = dsw_q;
  assign bus.title      = title_q;
  assign bus.loaded     = loaded_q;
endmodule
